// File: rtl/vec_mem_sequencer_if.sv
// Element-wide data-memory bus between vec_mem_sequencer (master) and memory (slave).
interface vec_mem_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int ELEM_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic [ELEM_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Runs one vector load/store as LANES element accesses on a single memory port.
// Optional VSEQ_STRIDE_EN adds a latched element stride; otherwise unit stride.
module vec_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
`ifdef VSEQ_STRIDE_EN
  input  logic [ADDR_W-1:0]       stride,
`endif
  input  logic [LANES*ELEM_W-1:0] wdata_vec,
  output logic [LANES*ELEM_W-1:0] rdata_vec,
  output logic                    stall,
  output logic                    done,
  vec_mem_sequencer_if.master     mem
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [LANES*ELEM_W-1:0] r_wdata_vec;
  logic [LANES*ELEM_W-1:0] r_rdata_vec;
  logic                    r_done;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic [ELEM_W-1:0]       r_mem_wdata;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [ADDR_W-1:0]       w_step;

`ifdef VSEQ_STRIDE_EN
  logic [ADDR_W-1:0]       r_stride;
  assign w_step = r_stride;
`else
  assign w_step = ADDR_W'(1);
`endif

  assign w_idx_nxt = r_idx + IDX_W'(1);

  // Address is accumulated by step each element, equal to base + idx*step mod 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wdata_vec <= '0;
      r_rdata_vec <= '0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef VSEQ_STRIDE_EN
      r_stride    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= S_ACCESS;
            r_idx       <= '0;
            r_wdata_vec <= wdata_vec;
            r_mem_req   <= 1'b1;
            r_mem_we    <= is_store;
            r_mem_addr  <= base_addr;
            r_mem_wdata <= wdata_vec[ELEM_W-1:0];
`ifdef VSEQ_STRIDE_EN
            r_stride    <= stride;
`endif
          end
        end
        S_ACCESS: begin
          if (mem.mem_ack) begin
            if (!r_mem_we)
              r_rdata_vec[r_idx*ELEM_W +: ELEM_W] <= mem.mem_rdata;
            if (r_idx == LAST_IDX) begin
              r_state   <= S_DONE;
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_idx       <= w_idx_nxt;
              r_mem_addr  <= r_mem_addr + w_step;
              r_mem_wdata <= r_wdata_vec[w_idx_nxt*ELEM_W +: ELEM_W];
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign stall         = ((r_state == S_IDLE) && start) || (r_state == S_ACCESS);
  assign done          = r_done;
  assign rdata_vec     = r_rdata_vec;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed self-checking bench for vec_mem_sequencer (LANES=4, ELEM_W=8, ADDR_W=32).
module tb_vec_mem_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [31:0] base_addr;
  logic [31:0] wdata_vec;
  logic [31:0] rdata_vec;
  logic        stall;
  logic        done;
`ifdef VSEQ_STRIDE_EN
  logic [31:0] stride;
`endif

  int n_checks = 0;
  int n_errors = 0;

  vec_mem_sequencer_if #(.ADDR_W(32), .ELEM_W(8)) memif ();

  vec_mem_sequencer #(.LANES(4), .ELEM_W(8), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
`ifdef VSEQ_STRIDE_EN
    .stride    (stride),
`endif
    .wdata_vec (wdata_vec),
    .rdata_vec (rdata_vec),
    .stall     (stall),
    .done      (done),
    .mem       (memif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++; if (memif.mem_req !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b exp 0", memif.mem_req); end
    n_checks++; if (memif.mem_we !== 1'b0) begin n_errors++; $display("FAIL rst_we: got %b exp 0", memif.mem_we); end
    n_checks++; if (memif.mem_addr !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h exp 0", memif.mem_addr); end
    n_checks++; if (memif.mem_wdata !== 8'h0) begin n_errors++; $display("FAIL rst_wdata: got %h exp 0", memif.mem_wdata); end
    n_checks++; if (rdata_vec !== 32'h0) begin n_errors++; $display("FAIL rst_rdata: got %h exp 0", rdata_vec); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b exp 0", done); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (memif.mem_req !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL rst_release_idle: req %b stall %b exp 0 0", memif.mem_req, stall); end
  endtask

  task automatic test_load();
    logic [7:0]  d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [31:0] a;
    int          stall_cnt = 0;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; base_addr = 32'h100; memif.mem_ack = 1'b1; #1;
    if (stall) stall_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; memif.mem_rdata = d[i]; #1;
      if (stall) stall_cnt++;
      a = 32'h100 + 32'(i);
      n_checks++; if (memif.mem_req !== 1'b1 || memif.mem_we !== 1'b0) begin n_errors++; $display("FAIL load_req[%0d]: req %b we %b exp 1 0", i, memif.mem_req, memif.mem_we); end
      n_checks++; if (memif.mem_addr !== a) begin n_errors++; $display("FAIL load_addr[%0d]: got %h exp %h", i, memif.mem_addr, a); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL load_early_done[%0d]: got %b exp 0", i, done); end
    end
    @(negedge clk); #1;
    if (stall) stall_cnt++;
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL load_done: got %b exp 1", done); end
    n_checks++; if (memif.mem_req !== 1'b0) begin n_errors++; $display("FAIL load_done_req: got %b exp 0", memif.mem_req); end
    n_checks++; if (rdata_vec !== 32'h44332211) begin n_errors++; $display("FAIL load_rdata: got %h exp 44332211", rdata_vec); end
    n_checks++; if (stall_cnt != 5) begin n_errors++; $display("FAIL load_stall_cycles: got %0d exp 5", stall_cnt); end
    @(negedge clk); #1;
    n_checks++; if (done !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL load_idle: done %b stall %b exp 0 0", done, stall); end
  endtask

  task automatic test_store_wrap();
    logic [31:0] a [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    logic [7:0]  w [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; base_addr = 32'hFFFF_FFFE; wdata_vec = 32'hDDCC_BBAA;
    memif.mem_ack = 1'b1; memif.mem_rdata = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; wdata_vec = 32'h0; #1;
      n_checks++; if (memif.mem_req !== 1'b1 || memif.mem_we !== 1'b1) begin n_errors++; $display("FAIL store_req[%0d]: req %b we %b exp 1 1", i, memif.mem_req, memif.mem_we); end
      n_checks++; if (memif.mem_addr !== a[i]) begin n_errors++; $display("FAIL store_addr[%0d]: got %h exp %h", i, memif.mem_addr, a[i]); end
      n_checks++; if (memif.mem_wdata !== w[i]) begin n_errors++; $display("FAIL store_wdata[%0d]: got %h exp %h", i, memif.mem_wdata, w[i]); end
    end
    @(negedge clk); #1;
    n_checks++; if (done !== 1'b1 || memif.mem_req !== 1'b0) begin n_errors++; $display("FAIL store_done: done %b req %b exp 1 0", done, memif.mem_req); end
    n_checks++; if (rdata_vec !== 32'h44332211) begin n_errors++; $display("FAIL store_rdata_kept: got %h exp 44332211", rdata_vec); end
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    logic        ack [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] a   [7] = '{32'h200, 32'h201, 32'h201, 32'h201, 32'h201, 32'h202, 32'h203};
    logic [7:0]  d   [7] = '{8'h55, 8'hEE, 8'hEE, 8'hEE, 8'h66, 8'h77, 8'h88};
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; base_addr = 32'h200; memif.mem_ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0; memif.mem_ack = ack[i]; memif.mem_rdata = d[i]; #1;
      n_checks++; if (memif.mem_req !== 1'b1 || memif.mem_addr !== a[i]) begin n_errors++; $display("FAIL wait_hold[%0d]: req %b addr %h exp 1 %h", i, memif.mem_req, memif.mem_addr, a[i]); end
      n_checks++; if (done !== 1'b0 || stall !== 1'b1) begin n_errors++; $display("FAIL wait_busy[%0d]: done %b stall %b exp 0 1", i, done, stall); end
    end
    @(negedge clk);
    memif.mem_ack = 1'b1; #1;
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL wait_done_delay: got %b exp 1", done); end
    n_checks++; if (rdata_vec !== 32'h88776655) begin n_errors++; $display("FAIL wait_rdata: got %h exp 88776655", rdata_vec); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [7:0]  d [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [31:0] a;
    int          done_cnt = 0;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; base_addr = 32'h300; memif.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = (i == 0); is_store = (i == 0); base_addr = (i == 0) ? 32'h999 : 32'h300;
      memif.mem_rdata = d[i]; #1;
      if (done) done_cnt++;
      a = 32'h300 + 32'(i);
      n_checks++; if (memif.mem_addr !== a || memif.mem_we !== 1'b0) begin n_errors++; $display("FAIL ign_access[%0d]: addr %h we %b exp %h 0", i, memif.mem_addr, memif.mem_we, a); end
    end
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; #1;
    if (done) done_cnt++;
    n_checks++; if (stall !== 1'b0 || done !== 1'b1) begin n_errors++; $display("FAIL ign_done_state: stall %b done %b exp 0 1", stall, done); end
    @(negedge clk);
    start = 1'b0; is_store = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      if (done) done_cnt++;
      n_checks++; if (memif.mem_req !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL ign_idle_ack[%0d]: req %b stall %b exp 0 0", i, memif.mem_req, stall); end
      @(negedge clk); #1;
    end
    n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL ign_done_count: got %0d exp 1", done_cnt); end
    n_checks++; if (rdata_vec !== 32'h04030201) begin n_errors++; $display("FAIL ign_rdata: got %h exp 04030201", rdata_vec); end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0]  d [4] = '{8'h05, 8'h06, 8'h07, 8'h08};
    logic [31:0] a;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; base_addr = 32'h400; memif.mem_ack = 1'b1; memif.mem_rdata = 8'hA1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (memif.mem_addr !== 32'h402 || memif.mem_req !== 1'b1) begin n_errors++; $display("FAIL rmid_idx2: addr %h req %b exp 402 1", memif.mem_addr, memif.mem_req); end
    rst_n = 1'b0; #1;
    n_checks++; if (memif.mem_req !== 1'b0 || memif.mem_addr !== 32'h0 || memif.mem_we !== 1'b0) begin n_errors++; $display("FAIL rmid_async_bus: req %b addr %h we %b exp 0 0 0", memif.mem_req, memif.mem_addr, memif.mem_we); end
    n_checks++; if (rdata_vec !== 32'h0 || stall !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL rmid_async_out: rdata %h stall %b done %b exp 0 0 0", rdata_vec, stall, done); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (memif.mem_req !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL rmid_no_req[%0d]: req %b done %b exp 0 0", i, memif.mem_req, done); end
    end
    @(negedge clk);
    start = 1'b1; base_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; memif.mem_rdata = d[i]; #1;
      a = 32'h10 + 32'(i);
      n_checks++; if (memif.mem_addr !== a || memif.mem_req !== 1'b1) begin n_errors++; $display("FAIL rmid_restart_addr[%0d]: addr %h req %b exp %h 1", i, memif.mem_addr, memif.mem_req, a); end
    end
    @(negedge clk); #1;
    n_checks++; if (done !== 1'b1 || rdata_vec !== 32'h08070605) begin n_errors++; $display("FAIL rmid_restart_done: done %b rdata %h exp 1 08070605", done, rdata_vec); end
    @(negedge clk);
  endtask

`ifdef VSEQ_STRIDE_EN
  task automatic test_stride();
    logic [31:0] a;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; base_addr = 32'h40; stride = 32'h4; memif.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; stride = 32'h0; #1;
      a = 32'h40 + 32'(4 * i);
      n_checks++; if (memif.mem_addr !== a) begin n_errors++; $display("FAIL stride_addr[%0d]: got %h exp %h", i, memif.mem_addr, a); end
    end
    @(negedge clk); #1;
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL stride_done: got %b exp 1", done); end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; wdata_vec = '0;
    memif.mem_rdata = '0; memif.mem_ack = 1'b0;
`ifdef VSEQ_STRIDE_EN
    stride = '0;
`endif
    test_reset();
    test_load();
    test_store_wrap();
    test_wait_states();
    test_ignore_start();
    test_reset_mid_access();
`ifdef VSEQ_STRIDE_EN
    test_stride();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
